// File: rtl/fifo_thr.sv
// Single-clock FIFO with occupancy level, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise dout is registered.
module fifo_thr #(
    parameter int unsigned BITS_DEPTH = 8,
    parameter int unsigned BITS_WIDTH = 32,
    parameter int unsigned AF_THRESH  = 2**BITS_DEPTH - 4,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [BITS_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [BITS_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [BITS_DEPTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned        DEPTH    = 2**BITS_DEPTH;
    localparam logic [BITS_DEPTH:0] FULL_LVL = {1'b1, {BITS_DEPTH{1'b0}}};
    localparam logic [BITS_DEPTH:0] AF_LVL   = (BITS_DEPTH+1)'(AF_THRESH);
    localparam logic [BITS_DEPTH:0] AE_LVL   = (BITS_DEPTH+1)'(AE_THRESH);

    logic [BITS_WIDTH-1:0] mem [DEPTH];
    logic [BITS_DEPTH:0]   wr_ptr;
    logic [BITS_DEPTH:0]   rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // Flags depend only on the registered level, so no path from wr_en/rd_en.
    assign full         = (level == FULL_LVL);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // A write into a full FIFO is legal only when a read frees a slot on the same edge.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr[BITS_DEPTH-1:0]] <= din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign dout = mem[rd_ptr[BITS_DEPTH-1:0]];
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dout <= '0;
        end else if (rd_acc) begin
            dout <= mem[rd_ptr[BITS_DEPTH-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_thr.sv
// Scoreboard bench for fifo_thr (depth 8, AF=6, AE=2) against a queue-based reference model.
module tb_fifo_thr;

    localparam int unsigned BD    = 3;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [BW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [BW-1:0] dout;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [BD:0]   level;

    fifo_thr #(
        .BITS_DEPTH(BD),
        .BITS_WIDTH(BW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .clr_err     (clr_err),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int unsigned lvl;
        bit          ovf;
        bit          unf;
        bit          dchk;
        logic [BW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] model_q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [BW-1:0] m_last = '0;
    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: occupancy is simply the queue size; flags follow from it.
    task automatic step(input bit w, input bit r, input bit c, input logic [BW-1:0] d);
        exp_t e;
        bit   ra, wa;
        @(negedge i_clk);
        wr_en = w; rd_en = r; clr_err = c; din = d;
        @(posedge i_clk);
        ra = r && (model_q.size() != 0);
        wa = w && ((model_q.size() < DEPTH) || ra);
        if (ra) m_last = model_q.pop_front();
        if (wa) model_q.push_back(d);
        m_ovf = (w && !wa) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = (r && !ra) ? 1'b1 : (c ? 1'b0 : m_unf);
        e.lvl = model_q.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
`ifdef FIFO_FWFT_EN
        e.dchk = (model_q.size() != 0);
        e.d    = e.dchk ? model_q[0] : '0;
`else
        e.dchk = 1'b1;
        e.d    = m_last;
`endif
        sb.push_back(e);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("level", 32'(level), e.lvl);
            chk("full", 32'(full), 32'(e.lvl == DEPTH));
            chk("empty", 32'(empty), 32'(e.lvl == 0));
            chk("almost_full", 32'(almost_full), 32'(e.lvl >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(e.lvl <= AE));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("underflow", 32'(underflow), 32'(e.unf));
            if (e.dchk) chk("dout", 32'(dout), 32'(e.d));
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_almost_empty"}, 32'(almost_empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_almost_full"}, 32'(almost_full), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_underflow"}, 32'(underflow), 0);
`ifndef FIFO_FWFT_EN
        chk({tag, "_dout"}, 32'(dout), 0);
`endif
    endtask

    initial begin
        #1;
        check_reset_values("por");
        @(negedge i_clk);
        i_rst = 1'b0;

        // three words in, three out
        step(1, 0, 0, 16'h11);
        step(1, 0, 0, 16'h22);
        step(1, 0, 0, 16'h33);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);

        // fill past capacity: 9th write rejected, thresholds crossed on the way
        for (int i = 0; i < 9; i++) step(1, 0, 0, 16'(i));
        step(0, 0, 1, '0);
        // full with simultaneous read+write keeps level and raises no overflow
        step(1, 1, 0, 16'hAA);
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0);

        // empty read, and empty read+write: underflow set, write accepted
        step(0, 1, 0, '0);
        step(0, 0, 1, '0);
        step(1, 1, 0, 16'h5A);
        step(0, 1, 0, '0);

        // async reset at level 5 with sticky error still set
        step(0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h100 + 16'(i));
        @(negedge i_clk);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge i_clk);
        i_rst = 1'b0;
        model_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;

        // randomized traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 1000; i++) begin
            bit fill_phase;
            fill_phase = ((i / 60) % 2) == 0;
            step(($urandom_range(99) < (fill_phase ? 80 : 30)),
                 ($urandom_range(99) < (fill_phase ? 30 : 80)),
                 ($urandom_range(99) < 5),
                 BW'($urandom));
        end

        @(negedge i_clk);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
